// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: strobes the unified memory, captures the IF word
// into an instruction register and offers it to decode over valid/ready.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset, waiting for start
// FETCH   | present pc to memory with instr_req (or fault if out of range)
// CAPTURE | memory IF word valid; load instruction register, advance pc
// HOLD    | ir_valid high, waiting for decode to accept
// HALT    | HALT retired or fetch fault; only start or reset leaves
module fetch_sequencer #(
    parameter int unsigned PC_STEP  = 32,
    parameter int unsigned MEM_BITS = 1024,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [5:0]  HALT_OPC = 6'b110000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] pc_out,
    output logic        instr_req,
    input  logic [31:0] if_data,
    output logic [31:0] ir_out,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fetch_fault,
    output logic [15:0] retired_cnt
);

    localparam logic [31:0] LAST_PC    = 32'(MEM_BITS - PC_STEP);
    localparam logic [31:0] STEP       = 32'(PC_STEP);
    localparam logic [31:0] ALIGN_MASK = 32'(PC_STEP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] irpc_q, irpc_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            irpc_q  <= 32'd0;
            fault_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            irpc_q  <= irpc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_FETCH) || (state_q == S_CAPTURE) || (state_q == S_HOLD);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        irpc_d    = irpc_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        instr_req = 1'b0;
        ir_valid  = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    cnt_d   = 16'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (pc_q > LAST_PC) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    instr_req = 1'b1;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                ir_d    = if_data;
                irpc_d  = pc_q;
                pc_d    = pc_q + STEP;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                ir_valid = 1'b1;
                if (ir_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (ir_q[31:26] == HALT_OPC) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    pc_d    = RESET_PC;
                    cnt_d   = 16'd0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides capture, range fault and HALT entry; a handshake
        // in the same cycle has already been counted above.
        if (busy && redirect) begin
            ir_d    = ir_q;
            irpc_d  = irpc_q;
            pc_d    = redirect_pc & ~ALIGN_MASK;
            fault_d = fault_q | (|(redirect_pc & ALIGN_MASK));
            state_d = S_FETCH;
            if (state_q == S_FETCH) fault_d = fault_q | (|(redirect_pc & ALIGN_MASK));
        end
    end

    assign pc_out      = pc_q;
    assign ir_out      = ir_q;
    assign ir_pc       = irpc_q;
    assign fetch_fault = fault_q;
    assign retired_cnt = cnt_q;

endmodule
